// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Definitions shared by seq_serializer and the seq_detector stage it feeds:
// the serializer state encoding, the default word width and the pattern
// the detector looks for.
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int SEQ_DATA_W = 8;

    localparam logic SER_IDLE  = 1'b0;
    localparam logic SER_SHIFT = 1'b1;

    typedef enum logic {
        ST_IDLE  = SER_IDLE,
        ST_SHIFT = SER_SHIFT
    } ser_state_e;

    // Pattern recognised by seq_detector.
    localparam logic [3:0] SEQ_PATTERN = 4'b1011;

    // Bit-count register width for a given word width (at least one bit).
    function automatic int ser_cnt_w(input int data_w);
        return (data_w > 2) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/seq_serializer_if.sv
// -----------------------------------------------------------------------------
// seq_serializer_if
// Groups the parallel word handshake and the serial output side of
// seq_serializer.
//   in_data   : parallel word (DATA_W bits)
//   in_valid  : in_data valid
//   in_ready  : serializer can take a word this cycle
//   bit_en    : bit pacing strobe
//   ser_out   : serial bit
//   ser_valid : ser_out carries a data bit
//   word_done : one-cycle pulse after a word's last bit was consumed
//   busy      : shifting or holding a word
// master = word producer / serial consumer, slave = serializer.
// -----------------------------------------------------------------------------
interface seq_serializer_if
    import seq_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              bit_en;
    logic              ser_out;
    logic              ser_valid;
    logic              word_done;
    logic              busy;

    modport master (
        output in_data, in_valid, bit_en,
        input  in_ready, ser_out, ser_valid, word_done, busy
    );

    modport slave (
        input  in_data, in_valid, bit_en,
        output in_ready, ser_out, ser_valid, word_done, busy
    );
endinterface

// File: rtl/seq_serializer.sv
// -----------------------------------------------------------------------------
// seq_serializer
// Parallel-to-serial front end for seq_detector. Words arrive on a
// valid/ready handshake and are shifted out one bit per bit_en strobe.
// A one-word hold register lets consecutive words stream without an idle
// bit between them.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : seq_serializer_if.slave (handshake in, serial out)
// Parameters:
//   DATA_W    : word width (>= 2)
//   MSB_FIRST : 1 sends bit DATA_W-1 first, 0 sends bit 0 first
//   IDLE_BIT  : ser_out value while nothing is shifting
// -----------------------------------------------------------------------------
module seq_serializer
    import seq_pkg::*;
#(
    parameter int DATA_W    = SEQ_DATA_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    seq_serializer_if.slave bus
);

    localparam int                CNT_W    = ser_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    logic              accept;
    logic              last_bit;
    logic [DATA_W-1:0] shift_next;
    logic              head_bit;

    // The ready path only looks at reset and the hold flag, never at
    // in_valid, so the producer sees no combinational loop through us.
    assign bus.in_ready = rst && !hold_full_q;
    assign accept       = bus.in_valid && bus.in_ready;

    // last_bit: the head bit is consumed this cycle and it is the word's last.
    assign last_bit = (state_q == ST_SHIFT) && bus.bit_en && (cnt_q == CNT_LAST);

    // Shift away from the head; vacated positions fill with zero.
    assign shift_next = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0}
                                  : {1'b0, shift_q[DATA_W-1:1]};
    assign head_bit   = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = bus.in_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (bus.bit_en) begin
                    if (!last_bit) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                        end else if (accept) begin
                            // Word arriving on the last-bit cycle bypasses the
                            // hold register so the stream has no bubble.
                            shift_d = bus.in_data;
                        end else begin
                            shift_d = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end

                // An accept not consumed by the bypass above parks in hold.
                // accept implies the hold register is empty.
                if (accept && !last_bit) begin
                    hold_d      = bus.in_data;
                    hold_full_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Serial outputs are a single state-selected mux over registers.
    assign bus.ser_valid = (state_q == ST_SHIFT);
    assign bus.ser_out   = (state_q == ST_SHIFT) ? head_bit : IDLE_BIT;
    assign bus.word_done = done_q;
    assign bus.busy      = (state_q == ST_SHIFT) || hold_full_q;

endmodule

// File: tb/tb_seq_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_serializer
// Three serializer instances: u0 DATA_W=4 MSB first, u1 DATA_W=8 MSB first,
// u2 DATA_W=8 LSB first. A word-queue model of each instance is checked
// against the DUT outputs every cycle; directed scenarios add literal
// expectations on top.
// -----------------------------------------------------------------------------
module tb_seq_serializer;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic chk_en = 1'b0;

    // Stimulus per instance.
    logic [7:0] din [3];
    logic [2:0] vin = '0;
    logic [2:0] ben = '0;

    // Observed outputs per instance.
    logic [2:0] o_rdy, o_out, o_vld, o_done, o_busy;

    seq_serializer_if #(.DATA_W(4)) ifa ();
    seq_serializer_if #(.DATA_W(8)) ifb ();
    seq_serializer_if #(.DATA_W(8)) ifc ();

    seq_serializer #(.DATA_W(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0))
        u0 (.clk(clk), .rst(rst), .bus(ifa));
    seq_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0))
        u1 (.clk(clk), .rst(rst), .bus(ifb));
    seq_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0))
        u2 (.clk(clk), .rst(rst), .bus(ifc));

    assign ifa.in_data = din[0][3:0];
    assign ifb.in_data = din[1];
    assign ifc.in_data = din[2];
    assign ifa.in_valid = vin[0];
    assign ifb.in_valid = vin[1];
    assign ifc.in_valid = vin[2];
    assign ifa.bit_en = ben[0];
    assign ifb.bit_en = ben[1];
    assign ifc.bit_en = ben[2];

    assign o_rdy  = {ifc.in_ready,  ifb.in_ready,  ifa.in_ready};
    assign o_out  = {ifc.ser_out,   ifb.ser_out,   ifa.ser_out};
    assign o_vld  = {ifc.ser_valid, ifb.ser_valid, ifa.ser_valid};
    assign o_done = {ifc.word_done, ifb.word_done, ifa.word_done};
    assign o_busy = {ifc.busy,      ifb.busy,      ifa.busy};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: each instance holds up to two words; the front word is on the
    // wire, mi counts its bits already consumed.
    // ------------------------------------------------------------------
    int         WID [3] = '{4, 8, 8};
    bit         MSB [3] = '{1'b1, 1'b1, 1'b0};
    int         mn  [3] = '{0, 0, 0};
    int         mi  [3] = '{0, 0, 0};
    logic [7:0] mw0 [3] = '{8'h0, 8'h0, 8'h0};
    logic [7:0] mw1 [3] = '{8'h0, 8'h0, 8'h0};
    logic       md  [3] = '{1'b0, 1'b0, 1'b0};

    function automatic logic m_out(input int k);
        int idx;
        if (mn[k] == 0) return 1'b0;
        idx = MSB[k] ? (WID[k] - 1 - mi[k]) : mi[k];
        return mw0[k][idx];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int         n, i;
            logic [7:0] w0, w1;
            logic       d, acc;
            n = mn[k]; i = mi[k]; w0 = mw0[k]; w1 = mw1[k]; d = 1'b0;
            if (!rst) begin
                n = 0; i = 0;
            end else begin
                acc = vin[k] && (n < 2);
                if (n > 0 && ben[k]) begin
                    i++;
                    if (i == WID[k]) begin
                        w0 = w1; n--; i = 0; d = 1'b1;
                    end
                end
                if (acc) begin
                    if (n == 0) w0 = din[k]; else w1 = din[k];
                    n++;
                end
            end
            mn[k] <= n; mi[k] <= i; mw0[k] <= w0; mw1[k] <= w1; md[k] <= d;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("u%0d.ser_valid", k), 32'(o_vld[k]),  32'(mn[k] > 0));
                chk($sformatf("u%0d.ser_out", k),   32'(o_out[k]),  32'(m_out(k)));
                chk($sformatf("u%0d.busy", k),      32'(o_busy[k]), 32'(mn[k] > 0));
                chk($sformatf("u%0d.in_ready", k),  32'(o_rdy[k]),  32'(rst && (mn[k] < 2)));
                chk($sformatf("u%0d.word_done", k), 32'(o_done[k]), 32'(md[k]));
            end
        end
    end

    // Stand-in for seq_detector on u0's serial stream.
    logic [3:0] hist = '0;
    int         det_hits = 0;
    always @(posedge clk) begin
        if (!rst) hist <= '0;
        else if (ifa.ser_valid && ifa.bit_en) begin
            hist <= {hist[2:0], ifa.ser_out};
            if ({hist[2:0], ifa.ser_out} == SEQ_PATTERN) det_hits <= det_hits + 1;
        end
    end

    int done_b = 0;
    always @(posedge clk) if (ifb.word_done) done_b <= done_b + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] bits16;
    logic [23:0] bits24;
    logic [7:0]  bits8;
    logic [3:0]  exp4;
    int          base;

    initial begin
        for (int k = 0; k < 3; k++) din[k] = 8'h00;
        rst = 1'b0;
        ben = 3'b111;
        repeat (3) tick();
        // Reset state
        chk("rst.ser_valid", 32'(ifb.ser_valid), 32'd0);
        chk("rst.busy",      32'(ifb.busy),      32'd0);
        chk("rst.in_ready",  32'(ifb.in_ready),  32'd0);
        chk("rst.ser_out",   32'(ifb.ser_out),   32'd0);
        chk("rst.word_done", 32'(ifb.word_done), 32'd0);
        chk_en = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_release.in_ready", 32'(ifb.in_ready), 32'd1);
        tick();

        // 1: 4-bit word 1011 into the detector
        din[0] = 8'h0B; vin[0] = 1'b1;
        tick();
        vin[0] = 1'b0;
        exp4 = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1.ser_valid[%0d]", i), 32'(ifa.ser_valid), 32'd1);
            chk($sformatf("t1.ser_out[%0d]", i),   32'(ifa.ser_out),   32'(exp4[3-i]));
            tick();
        end
        chk("t1.word_done", 32'(ifa.word_done), 32'd1);
        chk("t1.ser_valid_end", 32'(ifa.ser_valid), 32'd0);
        tick();
        chk("t1.det_hits", 32'(det_hits), 32'd1);

        // 2: back-to-back A5, 3C
        base = done_b;
        din[1] = 8'hA5; vin[1] = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2.ser_valid[%0d]", i), 32'(ifb.ser_valid), 32'd1);
            bits16[15-i] = ifb.ser_out;
            if (i == 0) din[1] = 8'h3C;
            if (i == 1) begin
                vin[1] = 1'b0;
                chk("t2.in_ready_hold", 32'(ifb.in_ready), 32'd0);
                chk("t2.busy_hold",     32'(ifb.busy),     32'd1);
            end
            tick();
        end
        chk("t2.stream", 32'(bits16), 32'h0000A53C);
        chk("t2.ser_valid_end", 32'(ifb.ser_valid), 32'd0);
        tick();
        chk("t2.done_pulses", 32'(done_b - base), 32'd2);

        // 3: bit_en every third clock, F0
        din[1] = 8'hF0; vin[1] = 1'b1; ben[1] = 1'b0;
        tick();
        vin[1] = 1'b0;
        for (int c = 0; c < 24; c++) begin
            ben[1] = (c % 3 == 2);
            bits24[23-c] = ifb.ser_out;
            tick();
        end
        chk("t3.stream", 32'(bits24), 32'h00FFF000);
        chk("t3.word_done", 32'(ifb.word_done), 32'd1);
        chk("t3.ser_valid_end", 32'(ifb.ser_valid), 32'd0);
        chk("t3.idle_bit", 32'(ifb.ser_out), 32'd0);
        ben[1] = 1'b1;
        tick();

        // 4: reset mid-word with a held word pending
        base = done_b;
        din[1] = 8'hFF; vin[1] = 1'b1;
        tick();
        din[1] = 8'h55;
        tick();
        vin[1] = 1'b0;
        chk("t4.hold_full", 32'(ifb.in_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("t4.in_ready_rst", 32'(ifb.in_ready), 32'd0);
        tick();
        chk("t4.ser_valid", 32'(ifb.ser_valid), 32'd0);
        chk("t4.busy",      32'(ifb.busy),      32'd0);
        chk("t4.in_ready",  32'(ifb.in_ready),  32'd0);
        tick();
        chk("t4.in_ready_still", 32'(ifb.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("t4.in_ready_release", 32'(ifb.in_ready), 32'd1);
        repeat (10) tick();
        chk("t4.no_done", 32'(done_b - base), 32'd0);
        chk("t4.idle", 32'(ifb.ser_valid), 32'd0);

        // 5: LSB first, 01
        din[2] = 8'h01; vin[2] = 1'b1;
        tick();
        vin[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bits8[i] = ifc.ser_out;
            chk($sformatf("t5.ser_valid[%0d]", i), 32'(ifc.ser_valid), 32'd1);
            tick();
        end
        chk("t5.stream", 32'(bits8), 32'h01);
        chk("t5.word_done", 32'(ifc.word_done), 32'd1);

        // 6: accept lands on the last-bit cycle with hold empty
        base = done_b;
        din[1] = 8'h81; vin[1] = 1'b1;
        tick();
        vin[1] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t6.ser_valid[%0d]", i), 32'(ifb.ser_valid), 32'd1);
            bits16[15-i] = ifb.ser_out;
            if (i == 7) begin
                chk("t6.in_ready_last", 32'(ifb.in_ready), 32'd1);
                din[1] = 8'h7E; vin[1] = 1'b1;
            end
            if (i == 8) vin[1] = 1'b0;
            tick();
        end
        chk("t6.stream", 32'(bits16), 32'h0000817E);
        tick();
        chk("t6.done_pulses", 32'(done_b - base), 32'd2);

        repeat (3) tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
